reg_display_scheduler: RTL and testbench

Sequencer between the CPU debug register-read port and the LCD controller. It walks the register file on a dwell timer, or shows one manually selected register. For each register it reads the 32-bit value, converts it to sign plus 3 BCD digits with a sequential subtract loop, and handshakes one print with the LCD controller. It replaces the combinational two-digit decode in the core top level and widens the display range to ±999.

---
 rtl/reg_display_pkg.sv | 38 +++
 rtl/reg_display_scheduler_if.sv | 36 +++
 rtl/reg_display_scheduler_bin2bcd_seq.sv | 80 ++++++++
 rtl/reg_display_scheduler.sv | 162 ++++++++++++++++
 tb/tb_reg_display_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_display_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : reg_display_pkg                                              |
// | Description : Shared types and constants for the register display          |
// |               scheduler and its BCD converter.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package reg_display_pkg;

    localparam int DIGIT_W      = 4;
    localparam int MAX_MAG      = 999;
    localparam int STEP_H       = 100;
    localparam int STEP_T       = 10;
    localparam int MAG_W        = 10;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_AW       = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_SAMPLE   = 3'd2,
        ST_CONV_H   = 3'd3,
        ST_CONV_T   = 3'd4,
        ST_WAIT_LCD = 3'd5,
        ST_START    = 3'd6,
        ST_DWELL    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_H    = 2'd1,
        PH_T    = 2'd2
    } bcd_phase_t;

endpackage

`default_nettype wire

// File: rtl/reg_display_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | Module      : reg_display_scheduler_if                                     |
// | Description : Register-file debug read port plus LCD print handshake.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface reg_display_scheduler_if
    import reg_display_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = 32
);
    logic [AW-1:0]      reg_addr;
    logic [DW-1:0]      reg_data;
    logic               lcd_busy;
    logic               lcd_start;
    logic               sign;
    logic [DIGIT_W-1:0] digit2;
    logic [DIGIT_W-1:0] digit1;
    logic [DIGIT_W-1:0] digit0;
    logic               ovf;

    modport master (
        output reg_addr, lcd_start, sign, digit2, digit1, digit0, ovf,
        input  reg_data, lcd_busy
    );

    modport slave (
        input  reg_addr, lcd_start, sign, digit2, digit1, digit0, ovf,
        output reg_data, lcd_busy
    );

endinterface

`default_nettype wire

// File: rtl/reg_display_scheduler_bin2bcd_seq.sv
// +----------------------------------------------------------------------------+
// | Module      : bin2bcd_seq                                                  |
// | Description : Sequential 0..999 to 3-digit BCD converter (subtract loop).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module bin2bcd_seq
    import reg_display_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_start,
    input  wire logic [MAG_W-1:0]   i_mag,
    output logic                    o_hund_last,
    output logic                    o_done,
    output logic [DIGIT_W-1:0]      o_digit2,
    output logic [DIGIT_W-1:0]      o_digit1,
    output logic [DIGIT_W-1:0]      o_digit0
);

    bcd_phase_t          r_phase;
    bcd_phase_t          w_phase_next;
    logic [MAG_W-1:0]    r_mag;
    logic [DIGIT_W-1:0]  r_d2;
    logic [DIGIT_W-1:0]  r_d1;
    logic [DIGIT_W-1:0]  r_d0;
    logic                w_ge_h;
    logic                w_ge_t;

    assign w_ge_h      = (r_mag >= MAG_W'(STEP_H));
    assign w_ge_t      = (r_mag >= MAG_W'(STEP_T));
    assign o_hund_last = (r_phase == PH_H) && !w_ge_h;
    assign o_done      = (r_phase == PH_T) && !w_ge_t;
    assign o_digit2    = r_d2;
    assign o_digit1    = r_d1;
    assign o_digit0    = r_d0;

    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            PH_IDLE: if (i_start) w_phase_next = PH_H;
            PH_H:    if (!w_ge_h) w_phase_next = PH_T;
            PH_T:    if (!w_ge_t) w_phase_next = PH_IDLE;
            default: w_phase_next = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_mag   <= '0;
            r_d2    <= '0;
            r_d1    <= '0;
            r_d0    <= '0;
        end else begin
            r_phase <= w_phase_next;
            if (i_start) begin
                r_mag <= i_mag;
                r_d2  <= '0;
                r_d1  <= '0;
                r_d0  <= '0;
            end else if (r_phase == PH_H && w_ge_h) begin
                r_mag <= r_mag - MAG_W'(STEP_H);
                r_d2  <= r_d2 + DIGIT_W'(1);
            end else if (r_phase == PH_T) begin
                if (w_ge_t) begin
                    r_mag <= r_mag - MAG_W'(STEP_T);
                    r_d1  <= r_d1 + DIGIT_W'(1);
                end else begin
                    // remainder is below ten, so it is the units digit
                    r_d0 <= r_mag[DIGIT_W-1:0];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_display_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : reg_display_scheduler                                        |
// | Description : Walks the register file, converts each value to sign + 3     |
// |               BCD digits and hands one print per dwell to the LCD.         |
// |               Option macro: REG_DISPLAY_SKIP_ZERO_EN (skip zero registers).|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_display_scheduler
    import reg_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000000,
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int AW           = DEF_AW,
    parameter int DW           = 32
)(
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          enable,
    input  wire logic          hold,
    input  wire logic          manual_en,
    input  wire logic [AW-1:0] manual_addr,
    output logic               busy,
    reg_display_scheduler_if.master bus
);

    localparam int              DCW        = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL_CYCLES - 1);
    localparam logic [AW-1:0]   LAST_IDX   = AW'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [AW-1:0]       r_index;
    logic [AW-1:0]       w_index_next;
    logic [AW-1:0]       w_index_inc;
    logic [DCW-1:0]      r_dwell;
    logic                r_busy;
    logic                r_sign_w;
    logic                r_ovf_w;
    logic                r_sign;
    logic                r_ovf;
    logic [DIGIT_W-1:0]  r_d2;
    logic [DIGIT_W-1:0]  r_d1;
    logic [DIGIT_W-1:0]  r_d0;
    logic                w_neg;
    logic [DW-1:0]       w_mag_full;
    logic                w_big;
    logic                w_expire;
    logic                w_bcd_start;
    logic                w_hund_last;
    logic                w_bcd_done;
    logic [DIGIT_W-1:0]  w_bcd_d2;
    logic [DIGIT_W-1:0]  w_bcd_d1;
    logic [DIGIT_W-1:0]  w_bcd_d0;
    logic                w_load_out;

    // 0x80000000 negates to itself and still compares as > 999
    assign w_neg       = bus.reg_data[DW-1];
    assign w_mag_full  = w_neg ? (~bus.reg_data + DW'(1)) : bus.reg_data;
    assign w_big       = (w_mag_full > DW'(MAX_MAG));
    assign w_index_inc = (r_index == LAST_IDX) ? '0 : r_index + AW'(1);
    assign w_expire    = (r_state == ST_DWELL) && (r_dwell == DWELL_LAST);
    assign w_load_out  = (r_state == ST_WAIT_LCD) && !bus.lcd_busy;

    bin2bcd_seq u_bcd (
        .clk         (clk),
        .rst         (reset),
        .i_start     (w_bcd_start),
        .i_mag       (w_mag_full[MAG_W-1:0]),
        .o_hund_last (w_hund_last),
        .o_done      (w_bcd_done),
        .o_digit2    (w_bcd_d2),
        .o_digit1    (w_bcd_d1),
        .o_digit0    (w_bcd_d0)
    );

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_bcd_start  = 1'b0;
        case (r_state)
            ST_IDLE:     if (enable) w_state_next = ST_ADDR;
            ST_ADDR:     w_state_next = ST_SAMPLE;
            ST_SAMPLE: begin
`ifdef REG_DISPLAY_SKIP_ZERO_EN
                if (bus.reg_data == '0 && !manual_en) begin
                    w_index_next = w_index_inc;
                    w_state_next = ST_ADDR;
                end else
`endif
                if (w_big) begin
                    w_state_next = ST_WAIT_LCD;
                end else begin
                    w_bcd_start  = 1'b1;
                    w_state_next = ST_CONV_H;
                end
            end
            ST_CONV_H:   if (w_hund_last) w_state_next = ST_CONV_T;
            ST_CONV_T:   if (w_bcd_done) w_state_next = ST_WAIT_LCD;
            ST_WAIT_LCD: if (!bus.lcd_busy) w_state_next = ST_START;
            ST_START:    w_state_next = ST_DWELL;
            ST_DWELL: begin
                if (w_expire) begin
                    if (!enable) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_ADDR;
                        if (manual_en)  w_index_next = manual_addr;
                        else if (!hold) w_index_next = w_index_inc;
                    end
                end
            end
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_index  <= '0;
            r_dwell  <= '0;
            r_busy   <= 1'b0;
            r_sign_w <= 1'b0;
            r_ovf_w  <= 1'b0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
            r_d2     <= '0;
            r_d1     <= '0;
            r_d0     <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_dwell <= (r_state == ST_DWELL && !w_expire) ? r_dwell + DCW'(1) : '0;
            if (r_state == ST_SAMPLE) begin
                r_sign_w <= w_neg;
                r_ovf_w  <= w_big;
            end
            // outputs change only on entry to START and then hold until the next print
            if (w_load_out) begin
                r_sign <= r_sign_w;
                r_ovf  <= r_ovf_w;
                r_d2   <= r_ovf_w ? DIGIT_W'(9) : w_bcd_d2;
                r_d1   <= r_ovf_w ? DIGIT_W'(9) : w_bcd_d1;
                r_d0   <= r_ovf_w ? DIGIT_W'(9) : w_bcd_d0;
            end
        end
    end

    assign busy          = r_busy;
    assign bus.reg_addr  = r_index;
    assign bus.lcd_start = (r_state == ST_START);
    assign bus.sign      = r_sign;
    assign bus.ovf       = r_ovf;
    assign bus.digit2    = r_d2;
    assign bus.digit1    = r_d1;
    assign bus.digit0    = r_d0;

endmodule

`default_nettype wire

// File: tb/tb_reg_display_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_display_scheduler                                     |
// | Description : Directed table-driven bench for reg_display_scheduler.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reg_display_scheduler;
    import reg_display_pkg::*;

    typedef struct {
        logic [31:0] value;
        logic        sign;
        logic [3:0]  d2;
        logic [3:0]  d1;
        logic [3:0]  d0;
        logic        ovf;
        int          lat;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        hold;
    logic        manual_en;
    logic [4:0]  manual_addr;
    logic        busy;
    logic [31:0] regs [32];
    vec_t        vecs [8];
    int          tests;
    int          fails;

    reg_display_scheduler_if #(.AW(5), .DW(32)) bus ();

    reg_display_scheduler #(
        .DWELL_CYCLES (4),
        .NUM_REGS     (32),
        .AW           (5),
        .DW           (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .hold        (hold),
        .manual_en   (manual_en),
        .manual_addr (manual_addr),
        .busy        (busy),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.reg_data = regs[bus.reg_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        hold = 1'b0;
        manual_en = 1'b0;
        manual_addr = '0;
        bus.lcd_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // returns cycles from the call (made just after an edge) to lcd_start
    task automatic wait_start(input string name, output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus.lcd_start) begin
                ok = 1'b1;
                n = i + 1;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: lcd_start not seen within 300 cycles", name);
        end
    endtask

    task automatic check_digits(input string name, input logic s, input logic [3:0] d2,
                                input logic [3:0] d1, input logic [3:0] d0, input logic ov);
        check({name, "_sign"}, 32'(bus.sign), 32'(s));
        check({name, "_d2"}, 32'(bus.digit2), 32'(d2));
        check({name, "_d1"}, 32'(bus.digit1), 32'(d1));
        check({name, "_d0"}, 32'(bus.digit0), 32'(d0));
        check({name, "_ovf"}, 32'(bus.ovf), 32'(ov));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        bit  changed;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        vecs[0] = '{32'd37,        1'b0, 4'd0, 4'd3, 4'd7, 1'b0, 9,  "pos37"};
        vecs[1] = '{32'hFFFFFFFB,  1'b1, 4'd0, 4'd0, 4'd5, 1'b0, 6,  "neg5"};
        vecs[2] = '{32'd999,       1'b0, 4'd9, 4'd9, 4'd9, 1'b0, 24, "pos999"};
        vecs[3] = '{32'd1234,      1'b0, 4'd9, 4'd9, 4'd9, 1'b1, 4,  "ovf1234"};
        vecs[4] = '{32'h80000000,  1'b1, 4'd9, 4'd9, 4'd9, 1'b1, 4,  "ovfmin"};
        vecs[5] = '{32'd100,       1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 7,  "pos100"};
        vecs[6] = '{32'd1000,      1'b0, 4'd9, 4'd9, 4'd9, 1'b1, 4,  "ovf1000"};
        vecs[7] = '{32'hFFFFFC19,  1'b1, 4'd9, 4'd9, 4'd9, 1'b0, 24, "neg999"};

        // reset state with enable low
        do_reset();
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.lcd_start) seen = 1'b1;
        end
        check("rst_lcd_start", 32'(seen), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_reg_addr", 32'(bus.reg_addr), 0);
        check_digits("rst", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

        // single conversions from IDLE, latency and digits
        for (int v = 0; v < 8; v++) begin
            do_reset();
            regs[0] = vecs[v].value;
            enable = 1'b1;
            wait_start(vecs[v].name, n);
            check({vecs[v].name, "_lat"}, 32'(n), 32'(vecs[v].lat));
            check({vecs[v].name, "_addr"}, 32'(bus.reg_addr), 0);
            check({vecs[v].name, "_busy"}, 32'(busy), 1);
            check_digits(vecs[v].name, vecs[v].sign, vecs[v].d2, vecs[v].d1, vecs[v].d0, vecs[v].ovf);
            @(posedge clk);
            #1;
            check({vecs[v].name, "_pulse"}, 32'(bus.lcd_start), 0);
        end

        // LCD busy stalls the second print
        do_reset();
        regs[0] = 32'd37;
        hold = 1'b1;
        enable = 1'b1;
        wait_start("busy_first", n);
        bus.lcd_busy = 1'b1;
        regs[0] = 32'hFFFFFFFB;
        seen = 1'b0;
        changed = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.lcd_start) seen = 1'b1;
            if (bus.sign !== 1'b0 || bus.digit1 !== 4'd3 || bus.digit0 !== 4'd7) changed = 1'b1;
        end
        check("busy_no_start", 32'(seen), 0);
        check("busy_outputs_held", 32'(changed), 0);
        check("busy_flag", 32'(busy), 1);
        bus.lcd_busy = 1'b0;
        @(posedge clk);
        #1;
        check("busy_release_start", 32'(bus.lcd_start), 1);
        check_digits("busy_release", 1'b1, 4'd0, 4'd0, 4'd5, 1'b0);

        // index wrap, hold and manual precedence
        do_reset();
        for (int i = 0; i < 32; i++) regs[i] = 32'(i + 1);
        enable = 1'b1;
        manual_en = 1'b1;
        manual_addr = 5'd31;
        wait_start("seq_r0", n);
        check("seq_r0_addr", 32'(bus.reg_addr), 0);
        wait_start("seq_r31", n);
        check("seq_r31_addr", 32'(bus.reg_addr), 31);
        check_digits("seq_r31", 1'b0, 4'd0, 4'd3, 4'd2, 1'b0);
        manual_en = 1'b0;
        wait_start("seq_wrap", n);
        check("seq_wrap_addr", 32'(bus.reg_addr), 0);
        check("seq_wrap_d0", 32'(bus.digit0), 1);
        manual_en = 1'b1;
        manual_addr = 5'd5;
        wait_start("seq_r5", n);
        check("seq_r5_addr", 32'(bus.reg_addr), 5);
        manual_en = 1'b0;
        hold = 1'b1;
        wait_start("seq_hold", n);
        check("seq_hold_addr", 32'(bus.reg_addr), 5);
        check("seq_hold_d0", 32'(bus.digit0), 6);
        manual_en = 1'b1;
        manual_addr = 5'd9;
        wait_start("seq_manual", n);
        check("seq_manual_addr", 32'(bus.reg_addr), 9);
        check_digits("seq_manual", 1'b0, 4'd0, 4'd1, 4'd0, 1'b0);

        // reset while the tens loop of the second print is running
        do_reset();
        regs[0] = 32'd12;
        regs[7] = 32'd37;
        enable = 1'b1;
        manual_en = 1'b1;
        manual_addr = 5'd7;
        wait_start("midrst_first", n);
        check_digits("midrst_first", 1'b0, 4'd0, 4'd1, 4'd2, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("midrst_pre_addr", 32'(bus.reg_addr), 7);
        check("midrst_pre_busy", 32'(busy), 1);
        reset = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_start", 32'(bus.lcd_start), 0);
        check("midrst_addr", 32'(bus.reg_addr), 0);
        check_digits("midrst", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.lcd_start || busy) seen = 1'b1;
        end
        check("midrst_stays_idle", 32'(seen), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
